// File: rtl/secuenciador_ul.sv
// -----------------------------------------------------------------------------
// secuenciador_ul
//
// Drives a six-operation combinational logic unit through its select codes.
// One accepted start latches an operand set (a, b, c); the block then steps
// the select s through 0..N_OPS-1. Each unit result z is captured into a
// valid/ready output register and added into a running sum. Downstream
// back-pressure stalls the sweep, so every code is delivered exactly once.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a sweep (sampled only while idle)
//   a_in..c_in operand set, latched on an accepted start
//   a, b, c    latched operands to the logic unit, stable during a sweep
//   s          select code to the logic unit (never >= N_OPS)
//   z          combinational unit result for the current s
//   res_data   captured result
//   res_op     select code that produced res_data
//   res_valid  res_data/res_op hold a result
//   res_ready  downstream accepts when res_valid && res_ready
//   suma       running sum of captured results (W_OUT+3 bits, cannot overflow)
//   busy       sweep in progress (RUN or DRAIN)
//   done       one-cycle pulse once the last result has been accepted
// -----------------------------------------------------------------------------
module secuenciador_ul #(
    parameter int W_IN  = 8,
    parameter int W_OUT = 16,
    parameter int N_OPS = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W_IN-1:0]  a_in,
    input  logic [W_IN-1:0]  b_in,
    input  logic [W_IN-1:0]  c_in,
    output logic [W_IN-1:0]  a,
    output logic [W_IN-1:0]  b,
    output logic [W_IN-1:0]  c,
    output logic [2:0]       s,
    input  logic [W_OUT-1:0] z,
    output logic [W_OUT-1:0] res_data,
    output logic [2:0]       res_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W_OUT+2:0] suma,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [2:0] LAST_OP = 3'(N_OPS - 1);

    logic [1:0] state;
    logic       slot_free;

    // The output register can take a new result when it is empty or when its
    // current content is being accepted on this same edge.
    assign slot_free = !res_valid || res_ready;

    assign busy = (state == RUN) || (state == DRAIN);

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a         <= '0;
            b         <= '0;
            c         <= '0;
            s         <= '0;
            res_data  <= '0;
            res_op    <= '0;
            res_valid <= 1'b0;
            suma      <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a     <= a_in;
                        b     <= b_in;
                        c     <= c_in;
                        suma  <= '0;
                        s     <= '0;
                        state <= RUN;
                    end
                end

                RUN: begin
                    if (slot_free) begin
                        res_data  <= z;
                        res_op    <= s;
                        res_valid <= 1'b1;
                        suma      <= suma + {3'b000, z};
                        // The last code stays on s until the drain completes.
                        if (s == LAST_OP) begin
                            state <= DRAIN;
                        end else begin
                            s <= s + 3'd1;
                        end
                    end
                end

                DRAIN: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        done      <= 1'b1;
                        s         <= '0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_ul.sv
// -----------------------------------------------------------------------------
// tb_secuenciador_ul
//
// Self-checking bench for secuenciador_ul. A small behavioural model of the
// six-operation logic unit feeds z from the DUT's a/b/c/s. The basic sweep is
// checked cycle by cycle against a hand-computed vector table; back-pressure,
// alternating ready, start-while-busy, mid-sweep reset and maximum operands
// are covered by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_secuenciador_ul;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a_in, b_in, c_in;
    logic [7:0]  a, b, c;
    logic [2:0]  s;
    logic [15:0] z;
    logic [15:0] res_data;
    logic [2:0]  res_op;
    logic        res_valid;
    logic        res_ready;
    logic [18:0] suma;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0]  acc_op[$];
    logic [15:0] acc_data[$];
    int          done_pulses;
    bit          bad_s;
    bit          done_with_valid;

    secuenciador_ul #(.W_IN(8), .W_OUT(16), .N_OPS(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .a         (a),
        .b         (b),
        .c         (c),
        .s         (s),
        .z         (z),
        .res_data  (res_data),
        .res_op    (res_op),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .suma      (suma),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural logic unit: every code yields 0xFFFF when a=b=c=0xFF.
    function automatic logic [15:0] unit_model(input logic [7:0] ua, ub, uc,
                                               input logic [2:0] us);
        case (us)
            3'd0:    return {ua, ub};
            3'd1:    return {ub, uc};
            3'd2:    return {uc, ua};
            3'd3:    return {~(ua ^ ub), uc};
            3'd4:    return {ua | ub, ub & uc};
            3'd5:    return {uc, ua | ub};
            default: return 16'h0000;
        endcase
    endfunction

    always_comb z = unit_model(a, b, c, s);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle-by-cycle expectations for the basic sweep, sampled after E0..E8.
    typedef struct {
        logic        ready;
        logic        busy;
        logic        done;
        logic        valid;
        logic [2:0]  s;
        logic [2:0]  op;
        logic [15:0] data;
    } vec_t;

    vec_t tbl[9];

    // Runs one sweep. mode 0: ready high; 1: 3-cycle stall on res_op==2;
    // 2: alternating ready; 3: ready high plus a second start before E3.
    task automatic run_sweep(input int mode, input logic [7:0] ai, bi, ci,
                             output int done_edge);
        int k;
        int stalls_left;
        stalls_left = 3;
        acc_op.delete();
        acc_data.delete();
        done_pulses     = 0;
        bad_s           = 1'b0;
        done_with_valid = 1'b0;
        done_edge       = -1;

        a_in = ai; b_in = bi; c_in = ci;
        res_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        check("sweep_busy_after_e0", 32'(busy), 32'd1);
        check("sweep_s_after_e0", 32'(s), 32'd0);

        while (k < 60 && done_edge < 0) begin
            case (mode)
                1: begin
                    if (res_valid && res_op == 3'd2 && stalls_left > 0) begin
                        res_ready = 1'b0;
                        stalls_left--;
                    end else begin
                        res_ready = 1'b1;
                    end
                end
                2:       res_ready = (k % 2 == 0);
                default: res_ready = 1'b1;
            endcase
            if (mode == 3 && k == 2) begin
                start = 1'b1;
                a_in = 8'hAA; b_in = 8'hBB; c_in = 8'hCC;
            end else begin
                start = 1'b0;
            end
            if (res_valid && res_ready) begin
                acc_op.push_back(res_op);
                acc_data.push_back(res_data);
            end
            @(posedge clk); #1;
            k++;
            if (s >= 3'd6) bad_s = 1'b1;
            if (done && res_valid) done_with_valid = 1'b1;
            if (mode == 1 && !res_ready) begin
                check("stall_res_op_hold", 32'(res_op), 32'd2);
                check("stall_s_hold", 32'(s), 32'd3);
            end
            if (done) begin
                done_pulses++;
                done_edge = k;
            end
        end
        start = 1'b0;
        res_ready = 1'b1;
        if (done_edge < 0) check("sweep_timeout", 32'd1, 32'd0);

        @(posedge clk); #1;
        check("done_single_cycle", 32'(done), 32'd0);
        check("idle_busy_low", 32'(busy), 32'd0);
        check("s_never_out_of_range", 32'(bad_s), 32'd0);
        check("done_never_with_valid", 32'(done_with_valid), 32'd0);
        check("done_pulse_count", 32'(done_pulses), 32'd1);
    endtask

    // Compares the accepted stream against codes 0..5 with model data.
    task automatic check_stream(input string tag, input logic [7:0] ai, bi, ci);
        logic [18:0] exp_sum;
        exp_sum = '0;
        check({tag, "_count"}, 32'(acc_op.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            exp_sum += 19'(unit_model(ai, bi, ci, 3'(i)));
            if (i < acc_op.size()) begin
                check({tag, "_op"}, 32'(acc_op[i]), 32'(i));
                check({tag, "_data"}, 32'(acc_data[i]),
                      32'(unit_model(ai, bi, ci, 3'(i))));
            end
        end
        check({tag, "_suma"}, 32'(suma), 32'(exp_sum));
    endtask

    initial begin
        int de;

        // Hand-computed for a=0x12 b=0x34 c=0x56.
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 3'd0, 16'h1234};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 3'd1, 16'h3456};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 3'd2, 16'h5612};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 3'd3, 16'hD956};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 3'd4, 16'h3614};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 3'd5, 16'h5636};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 16'h0000};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000};

        rst_n = 1'b0;
        start = 1'b0;
        res_ready = 1'b0;
        a_in = '0; b_in = '0; c_in = '0;

        // Reset state.
        #12;
        check("rst_s", 32'(s), 32'd0);
        check("rst_abc", 32'({a, b, c}), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_op", 32'(res_op), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_suma", 32'(suma), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        #10 rst_n = 1'b1;

        // Basic sweep against the vector table; start is presented before E0.
        @(negedge clk);
        a_in = 8'h12; b_in = 8'h34; c_in = 8'h56;
        for (int i = 0; i < 9; i++) begin
            res_ready = tbl[i].ready;
            start = (i == 0);
            @(posedge clk); #1;
            start = 1'b0;
            check($sformatf("basic_busy_e%0d", i), 32'(busy), 32'(tbl[i].busy));
            check($sformatf("basic_done_e%0d", i), 32'(done), 32'(tbl[i].done));
            check($sformatf("basic_valid_e%0d", i), 32'(res_valid), 32'(tbl[i].valid));
            check($sformatf("basic_s_e%0d", i), 32'(s), 32'(tbl[i].s));
            if (tbl[i].valid) begin
                check($sformatf("basic_op_e%0d", i), 32'(res_op), 32'(tbl[i].op));
                check($sformatf("basic_data_e%0d", i), 32'(res_data), 32'(tbl[i].data));
            end
        end
        check("basic_suma", 32'(suma), 32'h2023C);
        repeat (3) @(posedge clk);
        #1;
        check("idle_suma_holds", 32'(suma), 32'h2023C);
        check("idle_abc_hold", 32'({a, b, c}), 32'h123456);

        // Back-pressure: three stalled cycles on res_op==2 delay done by 3.
        run_sweep(1, 8'h12, 8'h34, 8'h56, de);
        check("bp_done_edge", 32'(de), 32'd10);
        check_stream("bp", 8'h12, 8'h34, 8'h56);

        // Alternating ready.
        run_sweep(2, 8'h9C, 8'h07, 8'hE1, de);
        check_stream("alt", 8'h9C, 8'h07, 8'hE1);

        // Start while busy is ignored.
        run_sweep(3, 8'h01, 8'h80, 8'h3F, de);
        check("busy_start_done_edge", 32'(de), 32'd7);
        check("busy_start_abc", 32'({a, b, c}), 32'h01803F);
        check_stream("busy_start", 8'h01, 8'h80, 8'h3F);

        // Reset mid-sweep clears everything asynchronously.
        a_in = 8'h55; b_in = 8'h66; c_in = 8'h77;
        res_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(res_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_s", 32'(s), 32'd0);
        check("midrst_suma", 32'(suma), 32'd0);
        check("midrst_abc", 32'({a, b, c}), 32'd0);
        check("midrst_res", 32'({res_op, res_data}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(0, 8'h21, 8'h43, 8'h65, de);
        check("post_rst_done_edge", 32'(de), 32'd7);
        check_stream("post_rst", 8'h21, 8'h43, 8'h65);

        // Maximum operands: every result 0xFFFF, sum must not truncate.
        run_sweep(0, 8'hFF, 8'hFF, 8'hFF, de);
        for (int i = 0; i < acc_data.size(); i++)
            check("max_data", 32'(acc_data[i]), 32'h0000FFFF);
        check("max_suma", 32'(suma), 32'h5FFFA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
